lif_tdm_scheduler: RTL and testbench

//   Time-multiplexed sequencer sharing one leaky integrate-and-fire update datapath

---
 rtl/lif_tdm_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_lif_tdm_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler
//   One shared leaky integrate-and-fire datapath serves N_NEURONS virtual
//   neurons. A tick starts a sweep. Each slot is processed in three cycles:
//   LOAD reads its state, CALC applies leak/integrate/fire, and STORE writes
//   the result back. When the last slot is stored the FSM enters DONE, which
//   publishes the spike vector and raises a one-cycle done pulse.
//
// Handshake: tick is a plain strobe, with no ready signal. It is accepted
//   only when ena=1 and the FSM is IDLE. A tick that arrives while busy=1
//   (and ena=1) is dropped and sets the sticky overrun flag.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   ena               1 = advance, 0 = freeze every register
//   tick              timestep strobe that starts a sweep
//   cur_idx           slot whose input current is requested (0 when idle)
//   cur_in            input current for cur_idx, sampled in CALC
//   threshold         firing threshold, 0 disables firing
//   leak_shift        leak amount is V >> leak_shift
//   mon_sel, mem_mon  combinational membrane monitor
//   spike_vec         spikes of the last completed sweep
//   busy, done        FSM not idle / one-cycle end-of-sweep pulse
//   overrun           sticky flag: tick seen while busy
module lif_tdm_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int REFRAC    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         tick,
  output logic [$clog2(N_NEURONS)-1:0] cur_idx,
  input  logic [7:0]                   cur_in,
  input  logic [7:0]                   threshold,
  input  logic [2:0]                   leak_shift,
  input  logic [$clog2(N_NEURONS)-1:0] mon_sel,
  output logic [7:0]                   mem_mon,
  output logic [N_NEURONS-1:0]         spike_vec,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);

  localparam int IDX_W = $clog2(N_NEURONS);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(N_NEURONS - 1);
  localparam logic [1:0] REFRAC_L = 2'(REFRAC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CALC  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     slot_q, slot_d;
  logic [7:0]           v_q [N_NEURONS];
  logic [7:0]           v_d [N_NEURONS];
  logic [1:0]           refrac_q [N_NEURONS];
  logic [1:0]           refrac_d [N_NEURONS];
  logic [N_NEURONS-1:0] spk_q, spk_d;
  logic [N_NEURONS-1:0] spike_vec_q, spike_vec_d;
  logic                 overrun_q, overrun_d;
  // The pipeline registers between LOAD -> CALC -> STORE.
  logic [7:0]           ld_v_q, ld_v_d;
  logic [1:0]           ld_r_q, ld_r_d;
  logic [7:0]           res_v_q, res_v_d;
  logic [1:0]           res_r_q, res_r_d;
  logic                 res_s_q, res_s_d;

  // Shared integrate datapath. V - (V >> s) never goes negative, so the
  // 9-bit sum can only overflow upward, and that case clips to 255.
  logic [7:0] leak;
  logic [8:0] sum9;
  logic [7:0] v_sat;
  logic       fire;

  always_comb begin
    leak  = ld_v_q >> leak_shift;
    sum9  = {1'b0, ld_v_q} - {1'b0, leak} + {1'b0, cur_in};
    v_sat = sum9[8] ? 8'hFF : sum9[7:0];
    fire  = (threshold != 8'd0) && (v_sat >= threshold);
  end

  // State register process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      slot_q      <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]      <= '0;
        refrac_q[i] <= '0;
      end
      spk_q       <= '0;
      spike_vec_q <= '0;
      overrun_q   <= 1'b0;
      ld_v_q      <= '0;
      ld_r_q      <= '0;
      res_v_q     <= '0;
      res_r_q     <= '0;
      res_s_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      v_q         <= v_d;
      refrac_q    <= refrac_d;
      spk_q       <= spk_d;
      spike_vec_q <= spike_vec_d;
      overrun_q   <= overrun_d;
      ld_v_q      <= ld_v_d;
      ld_r_q      <= ld_r_d;
      res_v_q     <= res_v_d;
      res_r_q     <= res_r_d;
      res_s_q     <= res_s_d;
    end
  end

  // Next-state process. With ena=0 everything holds.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (ena) begin
      case (state_q)
        S_IDLE:  if (tick) begin
                   state_d = S_LOAD;
                   slot_d  = '0;
                 end
        S_LOAD:  state_d = S_CALC;
        S_CALC:  state_d = S_STORE;
        S_STORE: if (slot_q == LAST_SLOT) begin
                   state_d = S_DONE;
                 end else begin
                   state_d = S_LOAD;
                   slot_d  = slot_q + IDX_W'(1);
                 end
        S_DONE:  begin
                   state_d = S_IDLE;
                   slot_d  = '0;
                 end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and slot register updates.
  always_comb begin
    v_d         = v_q;
    refrac_d    = refrac_q;
    spk_d       = spk_q;
    spike_vec_d = spike_vec_q;
    overrun_d   = overrun_q;
    ld_v_d      = ld_v_q;
    ld_r_d      = ld_r_q;
    res_v_d     = res_v_q;
    res_r_d     = res_r_q;
    res_s_d     = res_s_q;
    if (ena) begin
      if (tick && state_q != S_IDLE) overrun_d = 1'b1;
      case (state_q)
        S_LOAD: begin
          ld_v_d = v_q[slot_q];
          ld_r_d = refrac_q[slot_q];
        end
        S_CALC: begin
          if (ld_r_q != 2'd0) begin
            res_v_d = 8'd0;
            res_r_d = ld_r_q - 2'd1;
            res_s_d = 1'b0;
          end else if (fire) begin
            res_v_d = 8'd0;
            res_r_d = REFRAC_L;
            res_s_d = 1'b1;
          end else begin
            res_v_d = v_sat;
            res_r_d = 2'd0;
            res_s_d = 1'b0;
          end
        end
        S_STORE: begin
          v_d[slot_q]      = res_v_q;
          refrac_d[slot_q] = res_r_q;
          spk_d[slot_q]    = res_s_q;
          // Publish on the edge that enters DONE, including the last slot's bit.
          if (slot_q == LAST_SLOT) spike_vec_d = spk_d;
        end
        default: ;
      endcase
    end
  end

  // Output process.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    cur_idx = '0;
    if (state_q == S_LOAD || state_q == S_CALC || state_q == S_STORE) cur_idx = slot_q;
  end

  assign mem_mon   = v_q[mon_sel];
  assign spike_vec = spike_vec_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
module tb_lif_tdm_scheduler;
  localparam int N      = 4;
  localparam int REFRAC = 2;
  localparam int IW     = $clog2(N);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          ena = 1'b0;
  logic          tick = 1'b0;
  logic [IW-1:0] cur_idx;
  logic [7:0]    cur_in = 8'd0;
  logic [7:0]    threshold = 8'd0;
  logic [2:0]    leak_shift = 3'd0;
  logic [IW-1:0] mon_sel = '0;
  logic [7:0]    mem_mon;
  logic [N-1:0]  spike_vec;
  logic          busy, done, overrun;

  lif_tdm_scheduler #(.N_NEURONS(N), .REFRAC(REFRAC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick), .cur_idx(cur_idx),
    .cur_in(cur_in), .threshold(threshold), .leak_shift(leak_shift),
    .mon_sel(mon_sel), .mem_mon(mem_mon), .spike_vec(spike_vec),
    .busy(busy), .done(done), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_phase counts enabled cycles since the accepted tick: 0 = idle,
  // 1..3N = slot work (three cycles per slot), 3N+1 = done cycle.
  int           m_phase;
  int           m_v [N];
  int           m_r [N];
  logic [N-1:0] m_pend;
  logic [N-1:0] m_sv;
  logic         m_ov;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      for (int i = 0; i < N; i++) begin m_v[i] = 0; m_r[i] = 0; end
      m_pend = '0;
      m_sv   = '0;
      m_ov   = 1'b0;
    end else if (ena) begin
      if (m_phase == 0) begin
        if (tick) m_phase = 1;
      end else begin
        if (tick) m_ov = 1'b1;
        // The second cycle of each slot is where inputs are used.
        if (m_phase % 3 == 2 && m_phase <= 3 * N) begin
          int s, sum;
          s = (m_phase - 2) / 3;
          if (m_r[s] > 0) begin
            m_v[s] = 0; m_r[s] = m_r[s] - 1; m_pend[s] = 1'b0;
          end else begin
            sum = m_v[s] - (m_v[s] >> leak_shift) + int'(cur_in);
            if (sum > 255) sum = 255;
            if (threshold != 0 && sum >= int'(threshold)) begin
              m_v[s] = 0; m_r[s] = REFRAC; m_pend[s] = 1'b1;
            end else begin
              m_v[s] = sum; m_pend[s] = 1'b0;
            end
          end
        end
        if (m_phase == 3 * N + 1) m_phase = 0;
        else begin
          m_phase = m_phase + 1;
          if (m_phase == 3 * N + 1) m_sv = m_pend;
        end
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    int exp_idx;
    exp_idx = (m_phase >= 1 && m_phase <= 3 * N) ? (m_phase - 1) / 3 : 0;
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("done", 32'(done), 32'(m_phase == 3 * N + 1));
    chk("cur_idx", 32'(cur_idx), 32'(exp_idx));
    chk("spike_vec", 32'(spike_vec), 32'(m_sv));
    chk("overrun", 32'(overrun), 32'(m_ov));
    if (m_phase == 0) chk("mem_mon", 32'(mem_mon), 32'(m_v[mon_sel]));
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic run_sweep();
    int n;
    tick = 1'b1; step(1); tick = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin step(1); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL sweep_timeout: busy still %0d after %0d cycles", busy, n);
    end
  endtask

  task automatic lit_mem(input string name, input int slot, input int exp);
    mon_sel = IW'(slot); #1;
    chk(name, 32'(mem_mon), 32'(exp));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int exp_v [6];
    int exp_sv [6];
    int c;
    exp_v  = '{10, 20, 30, 0, 0, 0};
    exp_sv = '{0, 0, 0, 15, 0, 0};

    // 1. reset with random inputs
    #1 rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ena = 1'($urandom_range(0, 1));
      tick = 1'($urandom_range(0, 1));
      cur_in = 8'($urandom_range(0, 255));
      threshold = 8'($urandom_range(0, 255));
      leak_shift = 3'($urandom_range(0, 7));
      mon_sel = IW'(i % N);
      step(1);
    end
    chk("reset_busy", 32'(busy), 0);
    chk("reset_spike_vec", 32'(spike_vec), 0);
    tick = 1'b0; ena = 1'b1;
    cur_in = 8'd10; threshold = 8'd40; leak_shift = 3'd7; mon_sel = '0;
    rst_n = 1'b1;
    step(2);

    // 2. integrate and fire, then refractory
    for (int t = 0; t < 6; t++) begin
      run_sweep();
      lit_mem("s2_mem", t % N, exp_v[t]);
      chk("s2_spike_vec", 32'(spike_vec), 32'(exp_sv[t]));
    end

    // 3. saturation with half leak
    cur_in = 8'd200; threshold = 8'd0; leak_shift = 3'd1;
    run_sweep();
    lit_mem("s3_mem_first", 1, 200);
    run_sweep();
    lit_mem("s3_mem_clip", 3, 255);
    chk("s3_spike_vec", 32'(spike_vec), 0);

    // 4. latency and overrun
    tick = 1'b1; step(1); tick = 1'b0; c = 1;
    while (done !== 1'b1 && c < 100) begin
      if (c == 3) tick = 1'b1;
      step(1); tick = 1'b0; c++;
    end
    chk("s4_done_latency", 32'(c), 13);
    chk("s4_overrun", 32'(overrun), 1);
    step(5);
    chk("s4_no_second_sweep", 32'(busy), 0);

    // 5. freeze mid-sweep
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    cur_in = 8'd10; threshold = 8'd40; leak_shift = 3'd7;
    chk("s5_overrun_cleared", 32'(overrun), 0);
    tick = 1'b1; step(1); tick = 1'b0; c = 1;
    while (done !== 1'b1 && c < 100) begin
      if (c == 6) ena = 1'b0;
      if (c == 11) ena = 1'b1;
      step(1); c++;
    end
    chk("s5_done_latency", 32'(c), 18);
    step(1);
    lit_mem("s5_mem", 0, 10);
    for (int t = 0; t < 3; t++) run_sweep();
    chk("s5_spike_vec", 32'(spike_vec), 15);
    lit_mem("s5_mem_fired", 2, 0);

    // 6. async reset mid-sweep
    run_sweep(); run_sweep();  // leave refractory, V back to 0
    cur_in = 8'd7;
    run_sweep();
    lit_mem("s6_pre_mem", 0, 7);
    tick = 1'b1; step(1); tick = 1'b0; c = 1;
    while (c < 7) begin step(1); c++; end
    #1 rst_n = 1'b0;
    #1;
    chk("s6_async_busy", 32'(busy), 0);
    chk("s6_async_mem", 32'(mem_mon), 0);
    chk("s6_async_cur_idx", 32'(cur_idx), 0);
    rst_n = 1'b1;
    step(1);
    run_sweep();
    lit_mem("s6_clean_mem0", 0, 7);
    lit_mem("s6_clean_mem3", 3, 7);
    chk("s6_clean_spike_vec", 32'(spike_vec), 0);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end
endmodule
